// File: rtl/dec_enc_pkg.sv
// Shared types and helpers for the decimal keypad encoder: key/BCD widths,
// controller states and the priority-encode / popcount functions.
package dec_enc_pkg;

   localparam int NUM_KEYS = 10;
   localparam int BCD_W    = 4;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_DEBOUNCE = 2'd1,
      ST_EMIT     = 2'd2,
      ST_RELEASE  = 2'd3
   } state_e;

   // Highest pressed digit wins; an all-zero input encodes as 0.
   function automatic logic [BCD_W-1:0] prio_encode(input logic [NUM_KEYS-1:0] keys);
      logic [BCD_W-1:0] code;
      code = {BCD_W{1'b0}};
      for (int i = 0; i < NUM_KEYS; i++) begin
         if (keys[i]) begin
            code = BCD_W'(i);
         end
      end
      return code;
   endfunction

   function automatic logic [BCD_W-1:0] popcount(input logic [NUM_KEYS-1:0] keys);
      logic [BCD_W-1:0] cnt;
      cnt = {BCD_W{1'b0}};
      for (int i = 0; i < NUM_KEYS; i++) begin
         cnt = cnt + BCD_W'(keys[i]);
      end
      return cnt;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for quasi-static inputs arriving from another
// clock domain; each bit is synchronized independently.
module sync_2ff #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta_q;
   logic [WIDTH-1:0] sync_q;

   // Metastability-settling pipeline.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= {WIDTH{1'b0}};
         sync_q <= {WIDTH{1'b0}};
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/decimal_key_encoder.sv
// Debounced decimal keypad to BCD encoder with a one-entry output holding
// register, valid/ready handshake and overrun reporting.
module decimal_key_encoder
   import dec_enc_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NUM_KEYS-1:0] key,
   output logic [BCD_W-1:0]    bcd,
   output logic                bcd_valid,
   input  logic                bcd_ready,
   output logic                multi_err,
   output logic                overrun
);

   localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

   logic [NUM_KEYS-1:0] key_s;
   logic [BCD_W-1:0]    key_code_s;
   logic                key_multi_s;
   logic                key_any_s;

   state_e              state_q, state_d;
   logic [7:0]          cnt_q, cnt_d;
   logic [BCD_W-1:0]    code_q, code_d;
   logic                multi_q, multi_d;
   logic [BCD_W-1:0]    bcd_q, bcd_d;
   logic                valid_q, valid_d;
   logic                merr_q, merr_d;
   logic                ovr_q, ovr_d;

   sync_2ff #(
      .WIDTH (NUM_KEYS)
   ) u_key_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (key),
      .q     (key_s)
   );

   assign key_code_s  = prio_encode(key_s);
   assign key_multi_s = (popcount(key_s) > 4'd1);
   assign key_any_s   = |key_s;

   // Debounce controller and holding-register next-state logic.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      code_d  = code_q;
      multi_d = multi_q;
      bcd_d   = bcd_q;
      merr_d  = merr_q;
      ovr_d   = 1'b0;

      if (valid_q && bcd_ready) begin
         valid_d = 1'b0;
      end else begin
         valid_d = valid_q;
      end

      case (state_q)
         ST_IDLE: begin
            if (key_any_s) begin
               code_d  = key_code_s;
               multi_d = key_multi_s;
               cnt_d   = 8'd0;
               state_d = ST_DEBOUNCE;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_DEBOUNCE: begin
            if (!key_any_s || (key_code_s != code_q)) begin
               state_d = ST_IDLE;
            end else if (cnt_q == CNT_LAST) begin
               cnt_d   = 8'd0;
               state_d = ST_EMIT;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         ST_EMIT: begin
            // A consumer draining the register this cycle frees it for the new digit.
            if (!valid_q || bcd_ready) begin
               bcd_d   = code_q;
               merr_d  = multi_q;
               valid_d = 1'b1;
            end else begin
               ovr_d = 1'b1;
            end
            cnt_d   = 8'd0;
            state_d = ST_RELEASE;
         end
         ST_RELEASE: begin
            if (key_any_s) begin
               cnt_d = 8'd0;
            end else if (cnt_q == CNT_LAST) begin
               cnt_d   = 8'd0;
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: begin
            cnt_d   = 8'd0;
            state_d = ST_IDLE;
         end
      endcase
   end

   // State, counter and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= 8'd0;
         code_q  <= 4'd0;
         multi_q <= 1'b0;
         bcd_q   <= 4'd0;
         valid_q <= 1'b0;
         merr_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         code_q  <= code_d;
         multi_q <= multi_d;
         bcd_q   <= bcd_d;
         valid_q <= valid_d;
         merr_q  <= merr_d;
         ovr_q   <= ovr_d;
      end
   end

   assign bcd       = bcd_q;
   assign bcd_valid = valid_q;
   assign multi_err = merr_q;
   assign overrun   = ovr_q;

endmodule

// File: tb/tb_decimal_key_encoder.sv
// Self-checking bench for decimal_key_encoder: directed scenarios with literal
// expectations plus randomized key/ready traffic against a behavioural model.
module tb_decimal_key_encoder;

   localparam int DC = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic [9:0] key = 10'd0;
   logic       bcd_ready = 1'b0;
   logic [3:0] bcd;
   logic       bcd_valid;
   logic       multi_err;
   logic       overrun;

   int vectors = 0;
   int miscompares = 0;

   decimal_key_encoder #(
      .DEBOUNCE_CYCLES (DC)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .key       (key),
      .bcd       (bcd),
      .bcd_valid (bcd_valid),
      .bcd_ready (bcd_ready),
      .multi_err (multi_err),
      .overrun   (overrun)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Highest pressed digit, scanning down from 9.
   function automatic int top_idx(input logic [9:0] k);
      int r;
      r = -1;
      for (int i = 9; i >= 0; i--) begin
         if (k[i] && r < 0) r = i;
      end
      return r;
   endfunction

   // Transaction monitor: accepted digits ({multi,digit}) and overrun pulses.
   int acc_cnt = 0;
   int acc_last = -1;
   int ovr_cnt = 0;
   always @(posedge clk) begin
      if (rst_n && bcd_valid && bcd_ready) begin
         acc_cnt  <= acc_cnt + 1;
         acc_last <= {27'd0, multi_err, bcd};
      end
      if (rst_n && overrun) ovr_cnt <= ovr_cnt + 1;
   end

   // Behavioural model: 0 waiting, 1 confirming, 2 emitting, 3 awaiting release.
   logic [9:0] m_p1 = 10'd0, m_p2 = 10'd0, m_ks;
   int  m_ph = 0, m_run = 0, m_code = 0, m_hcode = 0;
   bit  m_multi = 1'b0, m_hmulti = 1'b0, m_hv = 1'b0, m_ovr = 1'b0, m_rdy, m_nhv;

   initial begin : model
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            m_p1 = 10'd0; m_p2 = 10'd0; m_ph = 0; m_run = 0;
            m_hv = 1'b0; m_hcode = 0; m_hmulti = 1'b0; m_ovr = 1'b0;
         end else begin
            m_ks  = m_p2;
            m_rdy = bcd_ready;
            m_p2  = m_p1;
            m_p1  = key;
            m_ovr = 1'b0;
            m_nhv = m_hv && !m_rdy;
            case (m_ph)
               0: if (m_ks != 10'd0) begin
                     m_code  = top_idx(m_ks);
                     m_multi = ($countones(m_ks) > 1);
                     m_run   = 0;
                     m_ph    = 1;
                  end
               1: if (m_ks != 10'd0 && top_idx(m_ks) == m_code) begin
                     m_run++;
                     if (m_run == DC) m_ph = 2;
                  end else begin
                     m_ph = 0;
                  end
               2: begin
                     if (!m_hv || m_rdy) begin
                        m_nhv    = 1'b1;
                        m_hcode  = m_code;
                        m_hmulti = m_multi;
                     end else begin
                        m_ovr = 1'b1;
                     end
                     m_run = 0;
                     m_ph  = 3;
                  end
               default: if (m_ks == 10'd0) begin
                     m_run++;
                     if (m_run == DC) m_ph = 0;
                  end else begin
                     m_run = 0;
                  end
            endcase
            m_hv = m_nhv;
         end
      end
   end

   // Per-cycle comparison of DUT outputs against the model.
   initial begin : compare
      #20;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            chk("rst_valid", {31'd0, bcd_valid}, 32'd0);
            chk("rst_bcd", {28'd0, bcd}, 32'd0);
            chk("rst_multi", {31'd0, multi_err}, 32'd0);
            chk("rst_overrun", {31'd0, overrun}, 32'd0);
         end else begin
            chk("valid", {31'd0, bcd_valid}, {31'd0, m_hv});
            if (m_hv) begin
               chk("bcd", {28'd0, bcd}, m_hcode);
               chk("multi_err", {31'd0, multi_err}, {31'd0, m_hmulti});
            end
            chk("overrun", {31'd0, overrun}, {31'd0, m_ovr});
         end
      end
   end

   int a0, o0, rise, vcyc;

   initial begin : stimulus
      #2 rst_n = 1'b0;
      tick(3);
      chk("reset_valid", {31'd0, bcd_valid}, 32'd0);
      chk("reset_bcd", {28'd0, bcd}, 32'd0);
      rst_n = 1'b1;
      tick(2);

      // Single press of 5, consumer always ready.
      bcd_ready = 1'b1;
      a0 = acc_cnt; rise = -1; vcyc = 0;
      key = 10'b0000100000;
      for (int k = 1; k <= 20; k++) begin
         tick(1);
         if (bcd_valid) begin
            vcyc++;
            if (rise < 0) rise = k;
         end
      end
      chk("single_rise_edge", rise, DC + 4);
      chk("single_valid_cycles", vcyc, 1);
      chk("single_count", acc_cnt - a0, 1);
      chk("single_digit", acc_last, 5);
      key = 10'd0;
      tick(10);

      // Bounce on digit 3, then a steady hold.
      a0 = acc_cnt;
      for (int i = 0; i < 10; i++) begin
         key = (((i / 2) % 2) == 0) ? 10'b0000001000 : 10'd0;
         tick(1);
      end
      chk("bounce_quiet", acc_cnt - a0, 0);
      key = 10'b0000001000;
      tick(20);
      chk("bounce_count", acc_cnt - a0, 1);
      chk("bounce_digit", acc_last, 3);
      key = 10'd0;
      tick(10);

      // Two keys at once: 9 wins, flagged as multi.
      a0 = acc_cnt;
      key = 10'b1000000010;
      tick(15);
      chk("multi_count", acc_cnt - a0, 1);
      chk("multi_digit", acc_last, 16 + 9);
      key = 10'd0;
      tick(10);

      // Backpressure: 2 is held, 7 overruns.
      bcd_ready = 1'b0;
      a0 = acc_cnt; o0 = ovr_cnt;
      key = 10'b0000000100; tick(12);
      key = 10'd0;          tick(10);
      key = 10'b0010000000; tick(12);
      key = 10'd0;          tick(10);
      chk("bp_valid_held", {31'd0, bcd_valid}, 32'd1);
      chk("bp_bcd_kept", {28'd0, bcd}, 32'd2);
      chk("bp_overrun_pulses", ovr_cnt - o0, 1);
      chk("bp_nothing_taken", acc_cnt - a0, 0);
      bcd_ready = 1'b1;
      tick(1);
      chk("bp_drained_valid", {31'd0, bcd_valid}, 32'd0);
      chk("bp_drained_count", acc_cnt - a0, 1);
      chk("bp_drained_digit", acc_last, 2);
      tick(5);

      // Reset while digit 0 is being debounced.
      a0 = acc_cnt;
      key = 10'b0000000001;
      tick(4);
      rst_n = 1'b0;
      #1;
      chk("midrst_valid", {31'd0, bcd_valid}, 32'd0);
      chk("midrst_bcd", {28'd0, bcd}, 32'd0);
      chk("midrst_multi", {31'd0, multi_err}, 32'd0);
      chk("midrst_overrun", {31'd0, overrun}, 32'd0);
      tick(1);
      rst_n = 1'b1;
      rise = -1;
      for (int k = 1; k <= 20; k++) begin
         tick(1);
         if (bcd_valid && rise < 0) rise = k;
      end
      chk("midrst_rise_edge", rise, DC + 4);
      chk("midrst_count", acc_cnt - a0, 1);
      chk("midrst_digit", acc_last, 0);
      key = 10'd0;
      tick(10);

      // Randomized key patterns and consumer readiness.
      for (int it = 0; it < 300; it++) begin
         int sel, len;
         sel = $urandom_range(99, 0);
         len = $urandom_range(14, 1);
         if (sel < 55)      key = 10'd1 << $urandom_range(9, 0);
         else if (sel < 70) key = 10'($urandom);
         else               key = 10'd0;
         for (int c = 0; c < len; c++) begin
            bcd_ready = ($urandom_range(9, 0) < 6);
            tick(1);
         end
      end
      key = 10'd0;
      bcd_ready = 1'b1;
      tick(12);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/decimal_key_encoder.md
DECIMAL_KEY_ENCODER -- requirements
Module: decimal_key_encoder

Interface
REQ-001 The module SHALL have parameter DEBOUNCE_CYCLES, default 4, giving the number of consecutive stable cycles required to accept a press or a release (legal range 2..255).
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The module SHALL have port key, input, 10 bits: decimal key lines, active high, bit i = digit i, asynchronous to clk.
REQ-005 The module SHALL have port bcd, output, 4 bits: the encoded digit 0..9, valid while bcd_valid=1.
REQ-006 The module SHALL have port bcd_valid, output, 1 bit: the digit holding register is full.
REQ-007 The module SHALL have port bcd_ready, input, 1 bit: the consumer accepts bcd on a cycle where bcd_valid=1 and bcd_ready=1.
REQ-008 The module SHALL have port multi_err, output, 1 bit: qualifies bcd; more than one key was active when the digit was captured.
REQ-009 The module SHALL have port overrun, output, 1 bit: a one-cycle pulse when an accepted digit was dropped because the holding register was full.

Function
REQ-010 key SHALL pass through a 2-flop synchronizer; key_s denotes the synchronized value; all decisions use key_s only.
REQ-011 Encoding SHALL be priority-based, highest index wins: code = index of the highest set bit of key_s; multi = (popcount(key_s) > 1).
REQ-012 The FSM SHALL have states IDLE, DEBOUNCE, EMIT and RELEASE.
REQ-013 In IDLE, when key_s != 0, the FSM SHALL latch code and multi, clear the counter and go to DEBOUNCE; otherwise it stays in IDLE.
REQ-014 In DEBOUNCE, if key_s == 0 or code(key_s) != latched code, the FSM SHALL return to IDLE; otherwise it increments the counter and goes to EMIT after DEBOUNCE_CYCLES stable cycles.
REQ-015 In EMIT, which lasts exactly one cycle, the block SHALL load the holding register if bcd_valid=0, or if bcd_valid=1 and bcd_ready=1 that same cycle (back-to-back load).
REQ-016 In EMIT, if the holding register cannot be loaded, the block SHALL drop the new digit, pulse overrun for 1 cycle and leave the old bcd and multi_err unchanged; the FSM then goes to RELEASE.
REQ-017 In RELEASE, the FSM SHALL count consecutive cycles with key_s == 0, restart the count on any nonzero key_s, and go to IDLE after DEBOUNCE_CYCLES zero cycles; no second digit is emitted for a held key.
REQ-018 bcd_valid SHALL clear on the edge after a cycle with bcd_valid=1 and bcd_ready=1, unless REQ-015 reloads on that edge.
REQ-019 bcd, bcd_valid and multi_err SHALL be registered outputs with no combinational path from key or bcd_ready.
REQ-020 Latency: for key stable from edge 0, bcd_valid=1 SHALL be visible after edge DEBOUNCE_CYCLES+4 (2 sync, 1 IDLE, DEBOUNCE_CYCLES debounce, 1 EMIT), i.e. after edge 8 at default.
REQ-021 A change to a different key during DEBOUNCE SHALL restart debouncing via IDLE; a change of key during RELEASE SHALL be ignored until full release.

Reset
REQ-022 When rst_n=0, the block SHALL asynchronously force the FSM to IDLE, clear the counter and synchronizer flops, and set bcd=4'd0, bcd_valid=0, multi_err=0, overrun=0.
REQ-023 A reset asserted mid-press SHALL discard any captured digit; after release of reset a still-held key SHALL be debounced afresh and emitted once.

Structure
REQ-024 A shared package dec_enc_pkg SHALL hold the state enum, NUM_KEYS=10, BCD_W=4 and the priority-encode/popcount functions.
REQ-025 The synchronizer SHALL be a separate sub-module sync_2ff, parameterized by width and instantiated once with width 10.

Verification
REQ-026 The bench SHALL cover a single press: key=10'b0000100000 held 20 cycles, bcd_ready=1 -> exactly one bcd=5 with multi_err=0, bcd_valid high for 1 cycle, rising after edge 8.
REQ-027 The bench SHALL cover bounce: key toggles 0/bit3 every 2 cycles for 10 cycles, then holds bit3 -> no output during bounce, then one bcd=3.
REQ-028 The bench SHALL cover multi-key: key=10'b1000000010 held -> bcd=9, multi_err=1.
REQ-029 The bench SHALL cover backpressure: bcd_ready=0, press 2, release, press 7 -> bcd=2 stays valid, overrun pulses once at the 7 EMIT; then bcd_ready=1 -> 2 consumed, bcd_valid=0.
REQ-030 The bench SHALL cover reset mid-press: bit0 held, rst_n pulsed low during DEBOUNCE -> all outputs 0 immediately, then one bcd=0 after DEBOUNCE_CYCLES+4 edges post-reset.
